// File: rtl/rs232_pkg.sv
// Shared types and helpers for the configurable RS232 receiver.
// Holds the parity modes, FSM states, status bit positions and the parameter legality check.
package rs232_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

   // Positions inside the 3-bit status word {Break,FrameErr,ParityErr}
   localparam int ERR_W      = 3;
   localparam int ERR_PARITY = 0;
   localparam int ERR_FRAME  = 1;
   localparam int ERR_BREAK  = 2;

   function automatic bit cfg_legal(input int data_bits, input int parity, input int stop_bits,
                                    input int oversample, input int clk_div);
      return (data_bits >= 5) && (data_bits <= 8) &&
             (parity >= 0) && (parity <= 2) &&
             ((stop_bits == 1) || (stop_bits == 2)) &&
             (oversample >= 8) && (oversample <= 32) && ((oversample % 2) == 0) &&
             (clk_div >= 1);
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/rs232_rxd_cfg_if.sv
// Receiver-side signal bundle: serial input plus the host-facing frame FIFO handshake.
// Handshake: RxValid means the FIFO head (RxData/RxErr) is valid and held stable until taken;
// the head is popped on the rising edge where RxValid and RxReady are both 1.
interface rs232_rxd_cfg_if #(
   parameter int DATA_BITS = 8
);
   logic                 Rxd;
   logic [DATA_BITS-1:0] RxData;
   logic                 RxValid;
   logic                 RxReady;
   logic [2:0]           RxErr;
   logic                 Overrun;
   logic                 Busy;

   modport slave (
      input  Rxd,
      input  RxReady,
      output RxData,
      output RxValid,
      output RxErr,
      output Overrun,
      output Busy
   );

   modport master (
      output Rxd,
      output RxReady,
      input  RxData,
      input  RxValid,
      input  RxErr,
      input  Overrun,
      input  Busy
   );
endinterface

// File: rtl/rs232_sample_tick.sv
// Sample-tick generator: CLK_DIV prescaler feeding an OVERSAMPLE tick counter per bit.
// restart_i realigns tick 0 to the current cycle so sampling is centred on the detected edge.
module rs232_sample_tick #(
   parameter int OVERSAMPLE = 16,
   parameter int CLK_DIV    = 4
) (
   input  logic Clock,
   input  logic ResetN,
   input  logic restart_i,
   output logic sample_o,
   output logic commit_o,
   output logic bit_end_o
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int TW    = $clog2(OVERSAMPLE);
   localparam int MID   = OVERSAMPLE / 2;

   logic [DIV_W-1:0] div_q;
   logic [TW-1:0]    tick_q;
   logic             tick;

   assign tick      = (div_q == DIV_W'(CLK_DIV - 1));
   assign sample_o  = tick && ((tick_q == TW'(MID - 1)) || (tick_q == TW'(MID)) ||
                               (tick_q == TW'(MID + 1)));
   assign commit_o  = tick && (tick_q == TW'(MID + 1));
   assign bit_end_o = tick && (tick_q == TW'(OVERSAMPLE - 1));

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         div_q  <= '0;
         tick_q <= '0;
      end else if (restart_i) begin
         div_q  <= '0;
         tick_q <= '0;
      end else if (tick) begin
         div_q  <= '0;
         tick_q <= (tick_q == TW'(OVERSAMPLE - 1)) ? '0 : tick_q + TW'(1);
      end else begin
         div_q  <= div_q + DIV_W'(1);
      end
   end

endmodule

// File: rtl/rs232_rxd_cfg.sv
// Oversampling RS232 receiver with majority voting, parity/framing/break detection and a
// 2-entry first-word-fallthrough frame FIFO towards the host.
module rs232_rxd_cfg
   import rs232_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16,
   parameter int CLK_DIV    = 4
) (
   input  logic           Clock,
   input  logic           ResetN,
   rs232_rxd_cfg_if.slave rx,
   output rx_state_e      dbg_state_o
);

   localparam int      BCW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int      HW       = $clog2(CLK_DIV + 1);
   localparam int      EW       = ERR_W + DATA_BITS;
   localparam parity_e PAR_MODE = parity_e'(PARITY);

   generate
      if (!cfg_legal(DATA_BITS, PARITY, STOP_BITS, OVERSAMPLE, CLK_DIV)) begin : g_cfg_check
         $error("rs232_rxd_cfg: illegal parameter combination");
      end
   endgenerate

   // Input synchroniser; prev_q gives the 1->0 edge on the synchronised line
   logic sync1_q, sync2_q, prev_q;
   logic fall, restart;

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= rx.Rxd;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   rx_state_e state_q;
   logic      sample, commit, bit_end;

   assign fall    = prev_q & ~sync2_q;
   assign restart = (state_q == ST_IDLE) && fall;

   rs232_sample_tick #(
      .OVERSAMPLE(OVERSAMPLE),
      .CLK_DIV   (CLK_DIV)
   ) u_tick (
      .Clock    (Clock),
      .ResetN   (ResetN),
      .restart_i(restart),
      .sample_o (sample),
      .commit_o (commit),
      .bit_end_o(bit_end)
   );

   // samp_a_q/samp_b_q hold ticks M-1 and M; the live synchronised bit is tick M+1
   logic samp_a_q, samp_b_q, vote;

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         samp_a_q <= 1'b1;
         samp_b_q <= 1'b1;
      end else if (sample) begin
         samp_a_q <= samp_b_q;
         samp_b_q <= sync2_q;
      end
   end

   assign vote = maj3(samp_a_q, samp_b_q, sync2_q);

   logic [BCW-1:0]       bit_cnt_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 par_bit_q;
   logic                 stop_cnt_q;
   logic                 frame_err_q;
   logic                 first_stop_q;
   logic                 brk_wait_q;
   logic [HW-1:0]        hi_cnt_q;

   logic             last_stop, first_stop, par_exp, push;
   logic [ERR_W-1:0] err_d;

   always_comb begin
      last_stop  = (STOP_BITS == 1) || stop_cnt_q;
      first_stop = (stop_cnt_q == 1'b0) ? vote : first_stop_q;
      par_exp    = (PAR_MODE == PAR_ODD) ? ~(^data_q) : ^data_q;
      err_d              = '0;
      err_d[ERR_PARITY]  = (PAR_MODE != PAR_NONE) && (par_bit_q != par_exp);
      err_d[ERR_FRAME]   = frame_err_q | ~vote;
      err_d[ERR_BREAK]   = (data_q == '0) && ((PAR_MODE == PAR_NONE) || !par_bit_q) && !first_stop;
      push = (state_q == ST_STOP) && !brk_wait_q && commit && last_stop;
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         data_q       <= '0;
         par_bit_q    <= 1'b0;
         stop_cnt_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         first_stop_q <= 1'b1;
         brk_wait_q   <= 1'b0;
         hi_cnt_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (fall) begin
                  state_q     <= ST_START;
                  frame_err_q <= 1'b0;
                  brk_wait_q  <= 1'b0;
               end
            end
            ST_START: begin
               if (commit && vote) begin
                  state_q <= ST_IDLE;
               end else if (bit_end) begin
                  state_q   <= ST_DATA;
                  bit_cnt_q <= '0;
               end
            end
            ST_DATA: begin
               if (commit) data_q <= {vote, data_q[DATA_BITS-1:1]};
               if (bit_end) begin
                  if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                     state_q    <= (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                     stop_cnt_q <= 1'b0;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BCW'(1);
                  end
               end
            end
            ST_PARITY: begin
               if (commit) par_bit_q <= vote;
               if (bit_end) begin
                  state_q    <= ST_STOP;
                  stop_cnt_q <= 1'b0;
               end
            end
            ST_STOP: begin
               if (brk_wait_q) begin
                  // Leave a break only after the line has been high for one whole tick
                  if (!sync2_q) begin
                     hi_cnt_q <= '0;
                  end else if (hi_cnt_q == HW'(CLK_DIV - 1)) begin
                     state_q    <= ST_IDLE;
                     brk_wait_q <= 1'b0;
                  end else begin
                     hi_cnt_q <= hi_cnt_q + HW'(1);
                  end
               end else if (commit) begin
                  if (stop_cnt_q == 1'b0) first_stop_q <= vote;
                  if (!vote) frame_err_q <= 1'b1;
                  if (last_stop) begin
                     if (err_d[ERR_BREAK]) begin
                        brk_wait_q <= 1'b1;
                        hi_cnt_q   <= '0;
                     end else begin
                        state_q <= ST_IDLE;
                     end
                  end
               end else if (bit_end && !last_stop) begin
                  stop_cnt_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   logic [EW-1:0] mem_q [2];
   logic          wr_ptr_q, rd_ptr_q;
   logic [1:0]    cnt_q;
   logic          overrun_q;
   logic          valid, full, pop, do_push;
   logic [EW-1:0] head;

   assign valid   = (cnt_q != 2'd0);
   assign full    = (cnt_q == 2'd2);
   assign pop     = valid && rx.RxReady;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
   assign do_push = push && (!full || pop);
   assign head    = mem_q[rd_ptr_q];

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         mem_q[0]  <= '0;
         mem_q[1]  <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         cnt_q     <= 2'd0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= push && !do_push;
         if (do_push) begin
            mem_q[wr_ptr_q] <= {err_d, data_q};
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_q + 2'(do_push) - 2'(pop);
      end
   end

   assign rx.RxValid  = valid;
   assign rx.RxData   = valid ? head[DATA_BITS-1:0] : '0;
   assign rx.RxErr    = valid ? head[EW-1:DATA_BITS] : '0;
   assign rx.Overrun  = overrun_q;
   assign rx.Busy     = (state_q != ST_IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rs232_rxd_cfg.sv
// Bench for rs232_rxd_cfg: an 8N1 instance and a 7E2 instance driven with directed and random frames.
// Expected entries come from a frame-level model of the serial format.
module tb_rs232_rxd_cfg;
   import rs232_pkg::*;

   localparam int BIT_CLKS = 64;

   logic      clk;
   logic      rst_n;
   rx_state_e dbg8, dbg7;
   int        total = 0;
   int        bad   = 0;

   rs232_rxd_cfg_if #(.DATA_BITS(8)) if8 ();
   rs232_rxd_cfg_if #(.DATA_BITS(7)) if7 ();

   rs232_rxd_cfg #(
      .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16), .CLK_DIV(4)
   ) dut8 (
      .Clock(clk), .ResetN(rst_n), .rx(if8), .dbg_state_o(dbg8)
   );

   rs232_rxd_cfg #(
      .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(16), .CLK_DIV(4)
   ) dut7 (
      .Clock(clk), .ResetN(rst_n), .rx(if7), .dbg_state_o(dbg7)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Observed pops and pulse counters, sampled on the falling edge
   logic [10:0] obs8_q[$];
   logic [10:0] obs7_q[$];
   logic [10:0] exp_q[$];
   int          vcnt8 = 0;
   int          ovr8  = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (if8.RxValid && if8.RxReady) obs8_q.push_back({if8.RxErr, if8.RxData});
         if (if7.RxValid && if7.RxReady) obs7_q.push_back({if7.RxErr, 1'b0, if7.RxData});
         if (if8.RxValid) vcnt8++;
         if (if8.Overrun) ovr8++;
      end
   end

   // Frame-level model: entry {Break,FrameErr,ParityErr,data}
   function automatic logic [10:0] model_entry(input int data, input int db, input int pmode,
                                               input bit par, input bit s1, input bit s2,
                                               input int nstop);
      int ones;
      bit pe, fe, brk;
      ones = 0;
      for (int i = 0; i < db; i++) ones += (data >> i) & 1;
      pe = 1'b0;
      if (pmode == 1) pe = (par != ((ones % 2) == 0));
      if (pmode == 2) pe = (par != ((ones % 2) == 1));
      fe  = !s1 || ((nstop == 2) && !s2);
      brk = (data == 0) && ((pmode == 0) || !par) && !s1;
      return {brk, fe, pe, 8'(data)};
   endfunction

   function automatic logic [15:0] f8(input logic [7:0] d, input bit stop);
      logic [15:0] b;
      b = '0;
      b[8:1] = d;
      b[9] = stop;
      return b;
   endfunction

   function automatic logic [15:0] f7(input logic [6:0] d, input bit par, input bit s1, input bit s2);
      logic [15:0] b;
      b = '0;
      b[7:1] = d;
      b[8] = par;
      b[9] = s1;
      b[10] = s2;
      return b;
   endfunction

   task automatic drive(input int sel, input logic v);
      if (sel == 0) if8.Rxd = v;
      else if7.Rxd = v;
   endtask

   // Bits LSB first; gmask marks bits that get a one-tick inversion around the centre sample
   task automatic send_bits(input int sel, input logic [15:0] bits, input int n,
                            input logic [15:0] gmask);
      logic v;
      for (int b = 0; b < n; b++) begin
         for (int c = 0; c < BIT_CLKS; c++) begin
            v = bits[b] ^ (gmask[b] && (c >= 34) && (c < 38));
            drive(sel, v);
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic idle_line(input int sel, input int n);
      drive(sel, 1'b1);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_obs(input int sel, input int n);
      for (int i = 0; i < 4 * BIT_CLKS; i++) begin
         if (((sel == 0) ? obs8_q.size() : obs7_q.size()) >= n) break;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      #2;
      total++;
      if ({if8.RxValid, if8.RxData, if8.RxErr, if8.Overrun, if8.Busy} !== 14'd0) begin
         bad++;
         $display("FAIL reset8_outputs: got %h want 0",
                  {if8.RxValid, if8.RxData, if8.RxErr, if8.Overrun, if8.Busy});
      end
      total++;
      if ({if7.RxValid, if7.RxData, if7.RxErr, if7.Overrun, if7.Busy} !== 13'd0) begin
         bad++;
         $display("FAIL reset7_outputs: got %h want 0",
                  {if7.RxValid, if7.RxData, if7.RxErr, if7.Overrun, if7.Busy});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
      end
      total++;
      if (dbg8 !== ST_IDLE || if8.Busy !== 1'b0 || if8.RxValid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release_idle: state=%0d busy=%b valid=%b want 0/0/0",
                  dbg8, if8.Busy, if8.RxValid);
      end
   endtask

   task automatic test_basic_8n1;
      int v0;
      obs8_q.delete();
      v0 = vcnt8;
      send_bits(0, f8(8'hA5, 1'b1), 10, 16'h0);
      idle_line(0, 20);
      total++;
      if (obs8_q.size() !== 1) begin
         bad++;
         $display("FAIL basic_count: got %0d want 1", obs8_q.size());
      end else begin
         total++;
         if (obs8_q[0] !== {3'b000, 8'hA5}) begin
            bad++;
            $display("FAIL basic_entry: got %h want %h", obs8_q[0], {3'b000, 8'hA5});
         end
      end
      total++;
      if (vcnt8 - v0 !== 1) begin
         bad++;
         $display("FAIL basic_valid_cycles: got %0d want 1", vcnt8 - v0);
      end
      total++;
      if (if8.Busy !== 1'b0) begin
         bad++;
         $display("FAIL basic_busy: got %b want 0", if8.Busy);
      end
   endtask

   task automatic test_7e2_errors;
      obs7_q.delete();
      send_bits(1, f7(7'h55, 1'b1, 1'b1, 1'b1), 11, 16'h0);
      idle_line(1, 20);
      send_bits(1, f7(7'h55, 1'b0, 1'b1, 1'b0), 11, 16'h0);
      idle_line(1, BIT_CLKS);
      wait_obs(1, 2);
      total++;
      if (obs7_q.size() !== 2) begin
         bad++;
         $display("FAIL e72_count: got %0d want 2", obs7_q.size());
      end else begin
         total++;
         if (obs7_q[0] !== {3'b001, 8'h55}) begin
            bad++;
            $display("FAIL e72_parity: got %h want %h", obs7_q[0], {3'b001, 8'h55});
         end
         total++;
         if (obs7_q[1] !== {3'b010, 8'h55}) begin
            bad++;
            $display("FAIL e72_stop2: got %h want %h", obs7_q[1], {3'b010, 8'h55});
         end
      end
   endtask

   task automatic test_glitch_reject;
      int waited;
      obs8_q.delete();
      drive(0, 1'b0);
      repeat (20) begin
         @(posedge clk); #1;
      end
      drive(0, 1'b1);
      total++;
      if (if8.Busy !== 1'b1) begin
         bad++;
         $display("FAIL glitch_busy_rise: got %b want 1", if8.Busy);
      end
      waited = 0;
      while (if8.Busy === 1'b1 && waited < BIT_CLKS) begin
         @(posedge clk); #1;
         waited++;
      end
      total++;
      if (if8.Busy !== 1'b0) begin
         bad++;
         $display("FAIL glitch_busy_fall: busy=%b after %0d clocks want 0", if8.Busy, waited);
      end
      idle_line(0, BIT_CLKS);
      total++;
      if (obs8_q.size() !== 0 || if8.RxValid !== 1'b0) begin
         bad++;
         $display("FAIL glitch_no_push: pops=%0d valid=%b want 0/0", obs8_q.size(), if8.RxValid);
      end
   endtask

   task automatic test_overrun;
      int o0;
      obs8_q.delete();
      o0 = ovr8;
      if8.RxReady = 1'b0;
      send_bits(0, f8(8'h01, 1'b1), 10, 16'h0);
      send_bits(0, f8(8'h02, 1'b1), 10, 16'h0);
      send_bits(0, f8(8'h03, 1'b1), 10, 16'h0);
      idle_line(0, 10);
      total++;
      if (if8.RxValid !== 1'b1 || if8.RxData !== 8'h01) begin
         bad++;
         $display("FAIL ovr_head_held: valid=%b data=%h want 1/01", if8.RxValid, if8.RxData);
      end
      total++;
      if (ovr8 - o0 !== 1) begin
         bad++;
         $display("FAIL ovr_pulse: got %0d cycles want 1", ovr8 - o0);
      end
      repeat (2) begin
         if8.RxReady = 1'b1;
         @(posedge clk); #1;
         if8.RxReady = 1'b0;
         @(posedge clk); #1;
      end
      total++;
      if (obs8_q.size() !== 2) begin
         bad++;
         $display("FAIL ovr_pops: got %0d want 2", obs8_q.size());
      end else begin
         total++;
         if (obs8_q[0] !== {3'b000, 8'h01} || obs8_q[1] !== {3'b000, 8'h02}) begin
            bad++;
            $display("FAIL ovr_order: got %h %h want 001 002", obs8_q[0], obs8_q[1]);
         end
      end
      total++;
      if (if8.RxValid !== 1'b0) begin
         bad++;
         $display("FAIL ovr_empty: got %b want 0", if8.RxValid);
      end
      if8.RxReady = 1'b1;
   endtask

   task automatic test_break;
      obs8_q.delete();
      drive(0, 1'b0);
      repeat (20 * BIT_CLKS) begin
         @(posedge clk); #1;
      end
      total++;
      if (obs8_q.size() !== 1) begin
         bad++;
         $display("FAIL break_count: got %0d want 1", obs8_q.size());
      end else begin
         total++;
         if (obs8_q[0] !== {3'b110, 8'h00}) begin
            bad++;
            $display("FAIL break_entry: got %h want %h", obs8_q[0], {3'b110, 8'h00});
         end
      end
      total++;
      if (if8.Busy !== 1'b1) begin
         bad++;
         $display("FAIL break_hold_busy: got %b want 1", if8.Busy);
      end
      idle_line(0, BIT_CLKS);
      total++;
      if (if8.Busy !== 1'b0) begin
         bad++;
         $display("FAIL break_release: got %b want 0", if8.Busy);
      end
      obs8_q.delete();
      send_bits(0, f8(8'h3C, 1'b1), 10, 16'h0);
      idle_line(0, 20);
      total++;
      if (obs8_q.size() !== 1 || obs8_q[0] !== {3'b000, 8'h3C}) begin
         bad++;
         $display("FAIL break_next_frame: n=%0d got %h want %h", obs8_q.size(),
                  (obs8_q.size() > 0) ? obs8_q[0] : 11'h7FF, {3'b000, 8'h3C});
      end
   endtask

   task automatic test_reset_mid_and_majority;
      logic [15:0] bits;
      int o0;
      obs8_q.delete();
      o0 = ovr8;
      bits = f8(8'hFF, 1'b1);
      for (int k = 0; k < BIT_CLKS * 5 + 30; k++) begin
         drive(0, bits[k / BIT_CLKS]);
         @(posedge clk); #1;
      end
      total++;
      if (dbg8 !== ST_DATA) begin
         bad++;
         $display("FAIL midreset_in_data: state=%0d want %0d", dbg8, ST_DATA);
      end
      rst_n = 1'b0;
      #2;
      total++;
      if ({if8.RxValid, if8.RxData, if8.RxErr, if8.Overrun, if8.Busy} !== 14'd0 || dbg8 !== ST_IDLE) begin
         bad++;
         $display("FAIL midreset_outputs: got %h state=%0d want 0/0",
                  {if8.RxValid, if8.RxData, if8.RxErr, if8.Overrun, if8.Busy}, dbg8);
      end
      drive(0, 1'b1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      idle_line(0, BIT_CLKS);
      total++;
      if (obs8_q.size() !== 0 || ovr8 !== o0) begin
         bad++;
         $display("FAIL midreset_lost: pops=%0d overrun=%0d want 0/0", obs8_q.size(), ovr8 - o0);
      end
      send_bits(0, f8(8'h81, 1'b1), 10, 16'h0);
      idle_line(0, 20);
      send_bits(0, f8(8'h0F, 1'b1), 10, 16'h01FE);
      idle_line(0, 20);
      total++;
      if (obs8_q.size() !== 2) begin
         bad++;
         $display("FAIL post_reset_count: got %0d want 2", obs8_q.size());
      end else begin
         total++;
         if (obs8_q[0] !== {3'b000, 8'h81}) begin
            bad++;
            $display("FAIL post_reset_frame: got %h want %h", obs8_q[0], {3'b000, 8'h81});
         end
         total++;
         if (obs8_q[1] !== {3'b000, 8'h0F}) begin
            bad++;
            $display("FAIL majority_frame: got %h want %h", obs8_q[1], {3'b000, 8'h0F});
         end
      end
   endtask

   task automatic test_random(input int sel, input int nframes);
      int  data;
      bit  par, s1, s2;
      int  idx;
      logic [10:0] got;
      if (sel == 0) obs8_q.delete();
      else obs7_q.delete();
      exp_q.delete();
      for (int f = 0; f < nframes; f++) begin
         s1 = ($urandom_range(0, 3) != 0);
         s2 = ($urandom_range(0, 3) != 0);
         par = 1'($urandom_range(0, 1));
         if (sel == 0) begin
            data = $urandom_range(0, 255);
            exp_q.push_back(model_entry(data, 8, 0, 1'b0, s1, 1'b1, 1));
            send_bits(0, f8(8'(data), s1), 10, 16'h0);
         end else begin
            data = $urandom_range(0, 127);
            exp_q.push_back(model_entry(data, 7, 2, par, s1, s2, 2));
            send_bits(1, f7(7'(data), par, s1, s2), 11, 16'h0);
         end
         idle_line(sel, $urandom_range(8, 70));
      end
      wait_obs(sel, nframes);
      total++;
      if (((sel == 0) ? obs8_q.size() : obs7_q.size()) !== nframes) begin
         bad++;
         $display("FAIL random%0d_count: got %0d want %0d", sel,
                  (sel == 0) ? obs8_q.size() : obs7_q.size(), nframes);
      end
      idx = 0;
      while (exp_q.size() > 0 && ((sel == 0) ? obs8_q.size() : obs7_q.size()) > 0) begin
         got = (sel == 0) ? obs8_q.pop_front() : obs7_q.pop_front();
         total++;
         if (got !== exp_q[0]) begin
            bad++;
            $display("FAIL random%0d_frame%0d: got %h want %h", sel, idx, got, exp_q[0]);
         end
         void'(exp_q.pop_front());
         idx++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      if8.Rxd = 1'b1;
      if8.RxReady = 1'b1;
      if7.Rxd = 1'b1;
      if7.RxReady = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      test_reset;
      test_basic_8n1;
      test_7e2_errors;
      test_glitch_reject;
      test_overrun;
      test_break;
      test_reset_mid_and_majority;
      test_random(0, 12);
      test_random(1, 10);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
